dclk_monitor: RTL and testbench
===============================

Name: dclk_monitor

Overview:
Downstream consumer of the gated divided clock (`clkdiv` output ANDed with the enable). It treats the incoming clock as data and re-times it into the system clock domain. From it, the block produces a one-cycle tick, a programmable-modulus event counter with terminal-count pulse, a period measurement in system clocks, and a stall flag when the divided clock stops (enable low). It sits between the divider/gate stage and the LED/display/debug logic.

Parameters:
CW, 8, width of event counter and modulus input
PW, 16, width of period measurement
STALL_LIM, 1024, system-clock cycles without a tick before stall_o asserts (must be < 2^PW)

Ports:
clk_i  input  1  system clock; all flops rise-edge
rstn_i  input  1  synchronous active-low reset
dclk_i  input  1  gated divided clock from divider stage; treated as asynchronous data
clr_i  input  1  synchronous clear of counter, period and stall state
mod_i  input  CW  counter modulus; 0 means full 2^CW wrap
tick_o  output  1  one-cycle pulse per dclk_i rising edge
cnt_o  output  CW  event count, 0..mod_i-1
tc_o  output  1  one-cycle pulse when cnt_o wraps to 0
period_o  output  PW  clk cycles between last two ticks, saturating
period_vld_o  output  1  one-cycle pulse when period_o updates
stall_o  output  1  level: no tick for >= STALL_LIM cycles

Behaviour:
- Reset (rstn_i=0 at a clk edge): sync flops s1,s2,s3, warm-up counter, tick_o, cnt_o, tc_o, period_o, period_vld_o, stall_o, armed flag, and per_cnt all go to 0.
- Synchroniser: s1<=dclk_i, s2<=s1, s3<=s2. rise = s2 & ~s3.
- Warm-up: rise is masked until 3 edges after reset release. No spurious tick if dclk_i is high at release. Real edges inside the window are dropped.
- Tick latency: dclk_i first sampled high at edge n -> tick_o high for exactly one cycle after edge n+2. Minimum resolvable dclk_i high/low time is 2 clk cycles.
- Counter, on a tick edge:
  - If cnt_o == mod_i-1 (or == 2^CW-1 when mod_i=0): cnt_o<=0 and tc_o<=1 in the same cycle as tick_o.
  - Otherwise cnt_o<=cnt_o+1.
  - tc_o is 0 on all other cycles.
  - If mod_i is changed so that cnt_o >= mod_i-1, the next tick wraps to 0 with tc_o.
- Period: per_cnt increments every cycle, saturating at 2^PW-1.
  - On a tick edge: per_cnt<=1, armed<=1.
  - If armed was already 1: period_o<=per_cnt and period_vld_o<=1, both in the same cycle as tick_o.
  - Result: ticks in cycles t1,t2 give period_o = t2-t1. The first tick after reset/clear sets armed only; no period_vld_o.
  - A saturated per_cnt reports 2^PW-1.
- Stall: stall_o<=1 when per_cnt >= STALL_LIM and no tick this edge; stall_o<=0 on a tick edge. This applies from reset too: no dclk -> stall after STALL_LIM cycles.
- clr_i=1: cnt_o<=0, per_cnt<=0, armed<=0, stall_o<=0, tc_o<=0, period_vld_o<=0.
  - period_o holds its value.
  - Synchroniser and tick_o path are unaffected.
  - clr_i has priority over a simultaneous tick: the tick still appears on tick_o but is not counted.
- Reset mid-operation behaves identically to power-on reset, including the warm-up mask.

Test Plan:
- dclk_i = clk/4 square wave (2 high, 2 low), mod_i=0: tick_o every 4 cycles; 1st tick 3 edges after first high sample; period_vld_o from 2nd tick; period_o=4; cnt_o 0,1,2,...
- mod_i=5, dclk clk/8: cnt_o 1,2,3,4,0 with tc_o only on the 0 tick; period_o=8; mod_i=0 run to 255->0 gives tc_o.
- dclk_i held 1 through reset release: no tick_o; first tick only after a low-then-high sequence.
- Gate dclk_i low (en_i=0 upstream) with STALL_LIM=1024: stall_o rises exactly 1024 cycles after last tick per_cnt reload; next edge clears stall_o with tick_o; period_o = gap value (saturates at 65535 if gap exceeds).
- clr_i asserted in the same cycle as a tick, cnt_o=3: cnt_o=0, tick_o=1, no period_vld_o on next tick (re-arm), period_o unchanged until second tick.
- rstn_i=0 mid-run, cnt_o=7, stall_o=1: all outputs 0 next cycle; ticks resume after warm-up.

Source files
------------

// File: rtl/dclk_monitor_if.sv
// dclk_monitor_if: divided-clock input, control and status outputs of the clock monitor
interface dclk_monitor_if #(
    parameter int CW = 8,
    parameter int PW = 16
);
    logic          dclk_i;
    logic          clr_i;
    logic [CW-1:0] mod_i;
    logic          tick_o;
    logic [CW-1:0] cnt_o;
    logic          tc_o;
    logic [PW-1:0] period_o;
    logic          period_vld_o;
    logic          stall_o;

    modport master (
        output dclk_i, clr_i, mod_i,
        input  tick_o, cnt_o, tc_o, period_o, period_vld_o, stall_o
    );

    modport slave (
        input  dclk_i, clr_i, mod_i,
        output tick_o, cnt_o, tc_o, period_o, period_vld_o, stall_o
    );
endinterface

// File: rtl/dclk_monitor.sv
// dclk_monitor: re-times a gated divided clock as data and derives tick, modulo event count,
// period in system clocks and a stall flag
module dclk_monitor #(
    parameter int CW        = 8,
    parameter int PW        = 16,
    parameter int STALL_LIM = 1024
) (
    input logic           clk_i,
    input logic           rstn_i,
    dclk_monitor_if.slave mon
);
    logic          s1_q, s2_q, s3_q;
    logic [1:0]    warm_q, warm_d;
    logic          armed_q, armed_d;
    logic [PW-1:0] per_cnt_q, per_cnt_d;
    logic          tick_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tc_q, tc_d;
    logic [PW-1:0] period_q, period_d;
    logic          period_vld_q, period_vld_d;
    logic          stall_q, stall_d;
    logic          rise, wrap, clr;

    // edges are ignored until the synchroniser holds only post-reset samples
    assign rise = s2_q & ~s3_q & (warm_q == 2'd3);
    assign wrap = cnt_q >= mon.mod_i - CW'(1);
    assign clr  = mon.clr_i;

    always_comb begin
        warm_d       = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        cnt_d        = clr ? '0 : rise ? (wrap ? '0 : cnt_q + CW'(1)) : cnt_q;
        tc_d         = ~clr & rise & wrap;
        armed_d      = ~clr & (armed_q | rise);
        period_vld_d = ~clr & rise & armed_q;
        period_d     = period_vld_d ? per_cnt_q : period_q;
        per_cnt_d    = clr ? '0 : rise ? PW'(1) : (&per_cnt_q ? per_cnt_q : per_cnt_q + PW'(1));
        stall_d      = ~clr & ~rise & (stall_q | (per_cnt_q >= PW'(STALL_LIM)));
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            warm_q       <= '0;
            armed_q      <= 1'b0;
            per_cnt_q    <= '0;
            tick_q       <= 1'b0;
            cnt_q        <= '0;
            tc_q         <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            stall_q      <= 1'b0;
        end else begin
            s1_q         <= mon.dclk_i;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            warm_q       <= warm_d;
            armed_q      <= armed_d;
            per_cnt_q    <= per_cnt_d;
            tick_q       <= rise;
            cnt_q        <= cnt_d;
            tc_q         <= tc_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            stall_q      <= stall_d;
        end
    end

    assign mon.tick_o       = tick_q;
    assign mon.cnt_o        = cnt_q;
    assign mon.tc_o         = tc_q;
    assign mon.period_o     = period_q;
    assign mon.period_vld_o = period_vld_q;
    assign mon.stall_o      = stall_q;
endmodule

// File: tb/tb_dclk_monitor.sv
// tb_dclk_monitor: vector table, directed corner sequences and random stimulus for dclk_monitor,
// checked against an edge-timestamp reference model
module tb_dclk_monitor;
    localparam int STALL_LIM = 1024;
    localparam int PSAT      = 65535;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    dclk_monitor_if #(.CW(8), .PW(16)) bus ();

    dclk_monitor #(.CW(8), .PW(16), .STALL_LIM(STALL_LIM)) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .mon   (bus)
    );

    typedef struct {
        logic        rstn, dclk, clr;
        logic [7:0]  mod;
        logic        tick;
        logic [7:0]  cnt;
        logic        tc, vld;
        logic [15:0] period;
        logic        stall;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   n_tick, n_tc;

    // reference model: dclk samples since reset, edge timestamps, plain integer counts
    bit   hist[$];
    int   now = 0;
    int   anchor = 1;
    bit   m_tick, m_tc, m_vld, m_stall, m_armed;
    int   m_cnt, m_period;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, now);
        end
    endfunction

    function automatic void add(input logic rn, d, c, input logic [7:0] m, input logic t,
                                input logic [7:0] cn, input logic tc, v, input logic [15:0] p,
                                input logic s);
        tbl.push_back('{rn, d, c, m, t, cn, tc, v, p, s});
    endfunction

    function automatic void model_update(input logic rn, d, c, input logic [7:0] m);
        int me;
        now++;
        m_tick = 0;
        m_tc   = 0;
        m_vld  = 0;
        if (!rn) begin
            hist.delete();
            m_cnt = 0; m_period = 0; m_stall = 0; m_armed = 0;
            anchor = now + 1;
        end else begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            // tick when the sample two edges ago is high and the one before it low
            m_tick = (hist.size() == 4) && hist[1] && !hist[0];
            me = (m == 0) ? 256 : int'(m);
            if (c) begin
                m_cnt = 0; m_armed = 0; m_stall = 0;
                anchor = now + 1;
            end else if (m_tick) begin
                m_tc  = (m_cnt + 1 >= me);
                m_cnt = m_tc ? 0 : m_cnt + 1;
                if (m_armed) begin
                    m_period = (now - anchor > PSAT) ? PSAT : now - anchor;
                    m_vld = 1;
                end
                m_armed = 1; m_stall = 0;
                anchor = now;
            end else if (now - anchor >= STALL_LIM) m_stall = 1;
        end
    endfunction

    task automatic step(input logic rn, d, c, input logic [7:0] m);
        rstn = rn;
        bus.dclk_i = d;
        bus.clr_i  = c;
        bus.mod_i  = m;
        @(posedge clk);
        model_update(rn, d, c, m);
        @(negedge clk);
        chk("tick", bus.tick_o, m_tick);
        chk("cnt", bus.cnt_o, m_cnt);
        chk("tc", bus.tc_o, m_tc);
        chk("period_vld", bus.period_vld_o, m_vld);
        chk("period", bus.period_o, m_period);
        chk("stall", bus.stall_o, m_stall);
        if (bus.tick_o === 1'b1) n_tick++;
        if (bus.tc_o === 1'b1) n_tc++;
    endtask

    task automatic hold(input logic lvl, input int n, input logic [7:0] m);
        for (int i = 0; i < n; i++) step(1'b1, lvl, 1'b0, m);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ktick, kst, len, steps;
        logic lvl, rn, c;
        logic [7:0] m;

        // reset, then dclk = clk/4 with a clear landing on the fourth tick (cnt 3)
        add(0,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 0,0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 1,1,0,0,0,0);
        add(1,0,0,0, 0,1,0,0,0,0);
        add(1,1,0,0, 0,1,0,0,0,0);
        add(1,1,0,0, 0,1,0,0,0,0);
        add(1,0,0,0, 1,2,0,1,4,0);
        add(1,0,0,0, 0,2,0,0,4,0);
        add(1,1,0,0, 0,2,0,0,4,0);
        add(1,1,0,0, 0,2,0,0,4,0);
        add(1,0,0,0, 1,3,0,1,4,0);
        add(1,0,0,0, 0,3,0,0,4,0);
        add(1,1,0,0, 0,3,0,0,4,0);
        add(1,1,0,0, 0,3,0,0,4,0);
        add(1,0,1,0, 1,0,0,0,4,0);
        add(1,0,0,0, 0,0,0,0,4,0);
        add(1,1,0,0, 0,0,0,0,4,0);
        add(1,1,0,0, 0,0,0,0,4,0);
        add(1,0,0,0, 1,1,0,0,4,0);
        add(1,0,0,0, 0,1,0,0,4,0);
        add(1,1,0,0, 0,1,0,0,4,0);
        add(1,1,0,0, 0,1,0,0,4,0);
        add(1,0,0,0, 1,2,0,1,4,0);

        foreach (tbl[i]) begin
            step(tbl[i].rstn, tbl[i].dclk, tbl[i].clr, tbl[i].mod);
            chk("tbl_tick", bus.tick_o, tbl[i].tick);
            chk("tbl_cnt", bus.cnt_o, tbl[i].cnt);
            chk("tbl_tc", bus.tc_o, tbl[i].tc);
            chk("tbl_vld", bus.period_vld_o, tbl[i].vld);
            chk("tbl_period", bus.period_o, tbl[i].period);
            chk("tbl_stall", bus.stall_o, tbl[i].stall);
        end

        // run on to cnt 7, then gate dclk low and time the stall
        hold(0, 1, 0);
        for (int i = 0; i < 4; i++) begin hold(1, 2, 0); hold(0, 2, 0); end
        hold(1, 2, 0);
        ktick = -1; kst = -1;
        for (int i = 0; i < 1200; i++) begin
            step(1, 0, 0, 0);
            if (bus.tick_o === 1'b1) ktick = i;
            if (bus.stall_o === 1'b1 && kst < 0) kst = i;
        end
        chk("stall_delay", kst - ktick, STALL_LIM);
        chk("pre_reset_cnt", bus.cnt_o, 7);
        chk("pre_reset_stall", bus.stall_o, 1);

        // mid-run reset clears everything in the next cycle
        step(0, 0, 0, 0);
        chk("rst_tick", bus.tick_o, 0);
        chk("rst_cnt", bus.cnt_o, 0);
        chk("rst_tc", bus.tc_o, 0);
        chk("rst_vld", bus.period_vld_o, 0);
        chk("rst_period", bus.period_o, 0);
        chk("rst_stall", bus.stall_o, 0);

        // dclk high through reset release must not tick
        step(0, 1, 0, 0);
        n_tick = 0;
        hold(1, 12, 0);
        chk("no_spurious_tick", n_tick, 0);
        hold(0, 2, 0); hold(1, 2, 0); hold(0, 2, 0);
        chk("tick_after_low_high", n_tick, 1);

        // modulus 5 at clk/8
        step(1, 0, 1, 5);
        n_tick = 0; n_tc = 0;
        for (int i = 0; i < 12; i++) begin hold(1, 4, 5); hold(0, 4, 5); end
        chk("mod5_ticks", n_tick, 12);
        chk("mod5_tc", n_tc, 2);
        chk("mod5_cnt", bus.cnt_o, 2);
        chk("mod5_period", bus.period_o, 8);

        // shrinking the modulus below the count wraps on the next tick
        for (int i = 0; i < 3; i++) begin hold(1, 2, 2); hold(0, 2, 2); end

        // full 2^CW wrap with mod 0
        step(1, 0, 1, 0);
        n_tc = 0;
        for (int i = 0; i < 256; i++) begin hold(1, 2, 0); hold(0, 2, 0); end
        chk("wrap_tc", n_tc, 1);
        chk("wrap_cnt", bus.cnt_o, 0);

        // long gap: stall set, then the next edge clears it and reports the gap
        hold(0, 1100, 0);
        chk("gap_stall", bus.stall_o, 1);
        hold(1, 3, 0);
        chk("gap_tick", bus.tick_o, 1);
        chk("gap_stall_clr", bus.stall_o, 0);
        chk("gap_vld", bus.period_vld_o, 1);
        chk("gap_period", bus.period_o, 1104);

        // random dclk runs, clears, modulus changes and resets
        lvl = 0; m = 0; steps = 0;
        while (steps < 6000) begin
            len = ($urandom_range(0, 39) == 0) ? $urandom_range(1030, 1100) : $urandom_range(1, 8);
            lvl = ~lvl;
            if ($urandom_range(0, 19) == 0) m = 8'($urandom_range(0, 15));
            for (int i = 0; i < len; i++) begin
                c  = ($urandom_range(0, 63) == 0);
                rn = ($urandom_range(0, 599) != 0);
                step(rn, lvl, c, m);
                steps++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
